alu_cmd_sequencer: RTL and testbench

- Initiator side of the 4-bit ALU interface; the ALU only answers operand/opcode requests.
- Accepts operation commands over a valid/ready handshake and buffers them in a small FIFO.
- Issues each command to an external 4-bit ALU, samples the result and flags, optionally writes the result back to a 4-bit accumulator, and returns a response over a second valid/ready handshake.
- Sits between the NPC control logic and the ALU datapath.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_cmd_fifo.sv | 63 ++++++
 rtl/alu_cmd_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, FSM states and
// response flag bit positions.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_EQ  = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_e;

  localparam int unsigned FLG_C = 2;
  localparam int unsigned FLG_V = 1;
  localparam int unsigned FLG_Z = 0;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with first-word-fall-through head and occupancy
// count; DEPTH must be a power of two.
module alu_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 9
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issues queued commands to an external 4-bit ALU and returns responses.
// Optional ALU_STICKY_FLAGS_EN adds sticky carry/overflow tracking.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic         cmd_src,
  input  logic [W-1:0] cmd_imm,
  input  logic         cmd_wb,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_op,
  input  logic [W-1:0] alu_result,
  input  logic         alu_carry,
  input  logic         alu_overflow,
  input  logic         alu_zero,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_result,
  output logic [2:0]   rsp_flags,
  output logic [W-1:0] acc
`ifdef ALU_STICKY_FLAGS_EN
  ,
  input  logic         sticky_clr,
  output logic [1:0]   sticky_flags
`endif
);

  localparam int unsigned CW = 3 + 1 + W + 1;
  localparam int unsigned AW = $clog2(DEPTH);

  logic [CW-1:0] fifo_din, fifo_dout;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [AW:0]   fifo_count;
  logic [AW+1:0] occ_after_push;

  logic [2:0]    head_op;
  logic          head_src, head_wb;
  logic [W-1:0]  head_imm;
  logic [2:0]    flags_in;

  state_e        state_q, state_d;
  logic [W-1:0]  alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0]    alu_op_q, alu_op_d;
  logic          wb_q, wb_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [W-1:0]  rsp_result_q, rsp_result_d;
  logic [2:0]    rsp_flags_q, rsp_flags_d;
  logic [W-1:0]  acc_q, acc_d;
  logic          cmd_ready_q, cmd_ready_d;

  assign fifo_din  = {cmd_op, cmd_src, cmd_imm, cmd_wb};
  assign fifo_push = cmd_valid && cmd_ready_q;
  assign head_op   = fifo_dout[CW-1 -: 3];
  assign head_src  = fifo_dout[W+1];
  assign head_imm  = fifo_dout[W:1];
  assign head_wb   = fifo_dout[0];

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Ready looks only at occupancy plus this cycle's push, so a pop never
  // raises it early; it can only be conservative by one cycle.
  assign occ_after_push = {1'b0, fifo_count} + {{(AW+1){1'b0}}, fifo_push};
  assign cmd_ready_d    = (occ_after_push < (AW+2)'(DEPTH));

  always_comb begin
    flags_in        = '0;
    flags_in[FLG_C] = alu_carry;
    flags_in[FLG_V] = alu_overflow;
    flags_in[FLG_Z] = alu_zero;
  end

  always_comb begin
    state_d      = state_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    wb_d         = wb_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    acc_d        = acc_q;
    fifo_pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        rsp_result_d = alu_result;
        rsp_flags_d  = flags_in;
        rsp_valid_d  = 1'b1;
        if (wb_q) acc_d = alu_result;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = EXEC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // acc_q is already post-writeback here, so issue never sees a stale value.
    if (fifo_pop) begin
      alu_a_d  = acc_q;
      alu_b_d  = head_src ? acc_q : head_imm;
      alu_op_d = head_op;
      wb_d     = head_wb;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      wb_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      acc_q        <= '0;
      cmd_ready_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      wb_q         <= wb_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      acc_q        <= acc_d;
      cmd_ready_q  <= cmd_ready_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign acc        = acc_q;

`ifdef ALU_STICKY_FLAGS_EN
  logic [1:0] sticky_q, sticky_d;

  always_comb begin
    sticky_d = sticky_q;
    if (sticky_clr)
      sticky_d = '0;
    else if (state_q == EXEC)
      sticky_d = sticky_q | {alu_carry, alu_overflow};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) sticky_q <= '0;
    else        sticky_q <= sticky_d;
  end

  assign sticky_flags = sticky_q;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural 4-bit ALU.
// Define ALU_STICKY_FLAGS_EN to also exercise the sticky flag register.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0, cmd_ready;
  logic [2:0] cmd_op = '0;
  logic       cmd_src = 1'b0;
  logic [3:0] cmd_imm = '0;
  logic       cmd_wb = 1'b0;
  logic [3:0] alu_a, alu_b, alu_result;
  logic [2:0] alu_op;
  logic       alu_carry, alu_overflow, alu_zero;
  logic       rsp_valid, rsp_ready = 1'b0;
  logic [3:0] rsp_result, acc;
  logic [2:0] rsp_flags;
`ifdef ALU_STICKY_FLAGS_EN
  logic       sticky_clr = 1'b0;
  logic [1:0] sticky_flags;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [4:0] t;
  always_comb begin
    t            = '0;
    alu_result   = '0;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    alu_zero     = 1'b0;
    case (alu_op)
      OP_ADD: begin
        t = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result   = t[3:0];
        alu_carry    = t[4];
        alu_overflow = (alu_a[3] == alu_b[3]) && (t[3] != alu_a[3]);
      end
      OP_SUB: begin
        t = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
        alu_result   = t[3:0];
        alu_carry    = t[4];
        alu_overflow = (alu_a[3] != alu_b[3]) && (t[3] != alu_a[3]);
      end
      OP_NOT:  alu_result = ~alu_a;
      OP_AND:  alu_result = alu_a & alu_b;
      OP_OR:   alu_result = alu_a | alu_b;
      OP_XOR:  alu_result = alu_a ^ alu_b;
      OP_SLT:  alu_result = {3'b000, ($signed(alu_a) < $signed(alu_b))};
      default: alu_result = {3'b000, (alu_a == alu_b)};
    endcase
    alu_zero = (alu_result == 4'd0);
  end

  alu_cmd_sequencer #(
    .DEPTH (4),
    .W     (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_src      (cmd_src),
    .cmd_imm      (cmd_imm),
    .cmd_wb       (cmd_wb),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .alu_carry    (alu_carry),
    .alu_overflow (alu_overflow),
    .alu_zero     (alu_zero),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_flags    (rsp_flags),
    .acc          (acc)
`ifdef ALU_STICKY_FLAGS_EN
    ,
    .sticky_clr   (sticky_clr),
    .sticky_flags (sticky_flags)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic src, input logic [3:0] imm, input logic wb);
    int g = 0;
    cmd_op = op; cmd_src = src; cmd_imm = imm; cmd_wb = wb;
    cmd_valid = 1'b1;
    while (!cmd_ready && g < 20) begin step; g++; end
    chk("send_ready", 32'(cmd_ready), 1);
    step;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp;
    int g = 0;
    while (!rsp_valid && g < 20) begin step; g++; end
    chk("rsp_timeout", 32'(rsp_valid), 1);
  endtask

  task automatic do_op(input string tag, input logic [2:0] op, input logic src,
                       input logic [3:0] imm, input logic wb, input logic [3:0] exp_res,
                       input logic [2:0] exp_flags, input logic [3:0] exp_acc);
    int t0;
    send(op, src, imm, wb);
    t0 = cyc;
    wait_rsp();
    chk({tag, "_lat"}, 32'(cyc - t0), 2);
    chk({tag, "_res"}, 32'(rsp_result), 32'(exp_res));
    chk({tag, "_flg"}, 32'(rsp_flags), 32'(exp_flags));
    chk({tag, "_acc"}, 32'(acc), 32'(exp_acc));
    step;
  endtask

  initial begin
    int accepted;
    int last;
    int seen;

    repeat (2) step;
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_result", 32'(rsp_result), 0);
    chk("rst_rsp_flags", 32'(rsp_flags), 0);
    chk("rst_acc", 32'(acc), 0);
    chk("rst_alu_abop", {20'd0, alu_a, alu_b, 1'b0, alu_op}, 0);
`ifdef ALU_STICKY_FLAGS_EN
    chk("rst_sticky", 32'(sticky_flags), 0);
`endif
    rst_n = 1'b1;
    step;
    rsp_ready = 1'b1;

    // {C,V,Z}
    do_op("add5",  OP_ADD, 1'b0, 4'd5, 1'b1, 4'b0101, 3'b000, 4'd5);
    chk("hold_alu_b", 32'(alu_b), 5);
    do_op("add4",  OP_ADD, 1'b0, 4'd4, 1'b1, 4'b1001, 3'b010, 4'd9);
    do_op("sub9",  OP_SUB, 1'b0, 4'd9, 1'b1, 4'b0000, 3'b101, 4'd0);
    do_op("add3",  OP_ADD, 1'b0, 4'd3, 1'b1, 4'b0011, 3'b000, 4'd3);
    do_op("slt",   OP_SLT, 1'b0, 4'd5, 1'b0, 4'b0001, 3'b000, 4'd3);
    chk("hold_alu_op", 32'(alu_op), 32'(OP_SLT));
    do_op("addsrc", OP_ADD, 1'b1, 4'd0, 1'b0, 4'b0110, 3'b000, 4'd3);
    chk("src_alu_b", 32'(alu_b), 3);
    do_op("eqwb",  OP_EQ,  1'b1, 4'd9, 1'b1, 4'b0001, 3'b000, 4'd1);

    rsp_ready = 1'b0;
    cmd_op = OP_ADD; cmd_src = 1'b0; cmd_imm = 4'd1; cmd_wb = 1'b1;
    cmd_valid = 1'b1;
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      if (cmd_ready) accepted++;
      step;
    end
    cmd_valid = 1'b0;
    chk("bp_accepted", 32'(accepted), 5);
    chk("bp_ready_low", 32'(cmd_ready), 0);
    chk("bp_valid", 32'(rsp_valid), 1);
    chk("bp_result", 32'(rsp_result), 2);
    repeat (3) step;
    chk("bp_hold_valid", 32'(rsp_valid), 1);
    chk("bp_hold_result", 32'(rsp_result), 2);
    chk("bp_hold_ready", 32'(cmd_ready), 0);

    rsp_ready = 1'b1;
    last = 0;
    for (int i = 0; i < 5; i++) begin
      wait_rsp();
      chk("drain_result", 32'(rsp_result), 32'(2 + i));
      if (i > 0) chk("drain_gap", 32'(cyc - last), 2);
      last = cyc;
      step;
    end
    chk("drain_idle", 32'(rsp_valid), 0);
    chk("drain_acc", 32'(acc), 6);

    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(OP_ADD, 1'b0, 4'd1, 1'b1);
    chk("mr_valid", 32'(rsp_valid), 1);
    chk("mr_acc", 32'(acc), 7);
    rst_n = 1'b0;
    step;
    rst_n = 1'b1;
    chk("mr_rsp_valid", 32'(rsp_valid), 0);
    chk("mr_acc0", 32'(acc), 0);
    chk("mr_cmd_ready", 32'(cmd_ready), 1);
    rsp_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid) seen++;
      step;
    end
    chk("mr_no_rsp", 32'(seen), 0);

`ifdef ALU_STICKY_FLAGS_EN
    chk("sticky_after_rst", 32'(sticky_flags), 0);
    do_op("s_add7", OP_ADD, 1'b0, 4'd7, 1'b1, 4'd7, 3'b000, 4'd7);
    do_op("s_ovf",  OP_ADD, 1'b0, 4'd1, 1'b1, 4'd8, 3'b010, 4'd8);
    chk("sticky_ovf", 32'(sticky_flags), 1);
    do_op("s_clean", OP_ADD, 1'b0, 4'd1, 1'b1, 4'd9, 3'b000, 4'd9);
    chk("sticky_kept", 32'(sticky_flags), 1);
    sticky_clr = 1'b1;
    step;
    sticky_clr = 1'b0;
    chk("sticky_clr", 32'(sticky_flags), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
